// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the instruction-fetch queue.
// Holds the reset fetch address, instruction width, FSM encoding and queue entry layout.
// Also provides the word-alignment helper applied to redirect targets.
package fetch_queue_pkg;

  localparam int unsigned INSTR_WIDTH    = 32;
  localparam int unsigned ENTRY_WIDTH    = 2 * INSTR_WIDTH;
  localparam logic [31:0] FETCH_RESET_PC = 32'h0000_3000;

  typedef enum logic [1:0] {
    FQ_REQ  = 2'd0,
    FQ_WAIT = 2'd1,
    FQ_DROP = 2'd2
  } fq_state_e;

  typedef struct packed {
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fq_entry_t;

  // Redirect targets are forced onto a word boundary
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO holding {pc, instr} entries for the fetch queue.
// Latency: a push is visible at dout on the next cycle if the FIFO was empty.
// Backpressure: none internally; the producer reserves space, and pushing into a full FIFO is an assertion error.
module fetch_queue_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  // Storage, pointers (wrapping modulo DEPTH) and occupancy; clear drops all entries
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[AW'(i)] <= '0;
      end
    end else if (clr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  // A push into a full FIFO means upstream space reservation was broken
  always_ff @(posedge clk) begin
    if (!rst && !clr) begin
      assert (!(push && (count_q == CW'(DEPTH))));
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: sequential fetch with one outstanding imem request, buffered {pc, instr} to decode.
// Latency: grant in cycle N, response in N+1, ir_valid in N+2; throughput one word per two cycles.
// Backpressure: requests stop while the queue is full; redirect flushes the queue. Optional counters: FETCH_STAT_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   redirect,
  input  logic [31:0]            redirect_pc,
  output logic                   imem_req,
  output logic [31:0]            imem_addr,
  input  logic                   imem_gnt,
  input  logic                   imem_rvalid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic                   ir_valid,
  input  logic                   ir_ready,
  output logic [INSTR_WIDTH-1:0] ir_instr,
  output logic [31:0]            ir_pc
`ifdef FETCH_STAT_EN
  ,
  output logic [31:0]            stat_fetched,
  output logic [31:0]            stat_stall,
  output logic [31:0]            stat_flush
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fq_state_e   state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] count;
  logic        push;
  logic        pop;
  fq_entry_t   push_entry;
  fq_entry_t   head;

  // Space is reserved at request time, so a granted response always fits
  assign imem_req  = !rst && (state_q == FQ_REQ) && (count < CW'(DEPTH)) && !redirect;
  assign imem_addr = fetch_pc_q;

  assign ir_valid  = (count != '0);
  assign pop       = ir_valid && ir_ready && !redirect;
  assign push_entry = '{pc: fetch_pc_q, instr: imem_rdata};

  // Next state and fetch address; redirect overrides every other event in its cycle
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    push       = 1'b0;
    if (redirect) begin
      fetch_pc_d = align_pc(redirect_pc);
      unique case (state_q)
        FQ_REQ:  state_d = imem_gnt    ? FQ_DROP : FQ_REQ;
        FQ_WAIT: state_d = imem_rvalid ? FQ_REQ  : FQ_DROP;
        FQ_DROP: state_d = imem_rvalid ? FQ_REQ  : FQ_DROP;
        default: state_d = FQ_REQ;
      endcase
    end else begin
      unique case (state_q)
        FQ_REQ: begin
          if (imem_req && imem_gnt) state_d = FQ_WAIT;
        end
        FQ_WAIT: begin
          if (imem_rvalid) begin
            push       = 1'b1;
            fetch_pc_d = fetch_pc_q + 32'd4;
            state_d    = FQ_REQ;
          end
        end
        FQ_DROP: begin
          if (imem_rvalid) state_d = FQ_REQ;
        end
        default: state_d = FQ_REQ;
      endcase
    end
  end

  // FSM state and fetch address registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FQ_REQ;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  fetch_queue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head),
    .count (count)
  );

  assign ir_instr = head.instr;
  assign ir_pc    = head.pc;

`ifdef FETCH_STAT_EN
  logic [31:0] stat_fetched_q, stat_stall_q, stat_flush_q;

  // Event counters: pushes, full-and-blocked cycles, redirects; all wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_fetched_q <= '0;
      stat_stall_q   <= '0;
      stat_flush_q   <= '0;
    end else begin
      if (push) stat_fetched_q <= stat_fetched_q + 32'd1;
      if ((count == CW'(DEPTH)) && ir_valid && !ir_ready) stat_stall_q <= stat_stall_q + 32'd1;
      if (redirect) stat_flush_q <= stat_flush_q + 32'd1;
    end
  end

  assign stat_fetched = stat_fetched_q;
  assign stat_stall   = stat_stall_q;
  assign stat_flush   = stat_flush_q;
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue with a switchable single-cycle memory model.
// Auto mode grants every request and answers next cycle with addr ^ 32'hA5A5_0000; manual mode is driven step by step.
// Counters are checked only when FETCH_STAT_EN is defined.
module tb_fetch_queue;

  logic        clk;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ir_valid;
  logic        ir_ready;
  logic [31:0] ir_instr;
  logic [31:0] ir_pc;
`ifdef FETCH_STAT_EN
  logic [31:0] stat_fetched, stat_stall, stat_flush;
`endif

  int checks = 0;
  int errors = 0;

  // Memory model
  logic        mem_auto;
  logic        gnt_man;
  logic        rv_man;
  logic [31:0] rdata_man;
  logic        pend_q;
  logic [31:0] paddr_q;

  always @(posedge clk) begin
    pend_q  <= imem_req && imem_gnt;
    paddr_q <= imem_addr;
  end

  assign imem_gnt    = mem_auto ? imem_req : gnt_man;
  assign imem_rvalid = mem_auto ? pend_q : rv_man;
  assign imem_rdata  = mem_auto ? (paddr_q ^ 32'hA5A5_0000) : rdata_man;

  fetch_queue dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ir_valid    (ir_valid),
    .ir_ready    (ir_ready),
    .ir_instr    (ir_instr),
    .ir_pc       (ir_pc)
`ifdef FETCH_STAT_EN
    ,
    .stat_fetched (stat_fetched),
    .stat_stall   (stat_stall),
    .stat_flush   (stat_flush)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; redirect = 1'b0; redirect_pc = '0; ir_ready = 1'b1;
    mem_auto = 1'b1; gnt_man = 1'b0; rv_man = 1'b0; rdata_man = '0;
    #1;
    check("req_in_reset_t0", imem_req, 1'b0);

    // Reset state
    step();
    check("rst_req", imem_req, 1'b0);
    check("rst_valid", ir_valid, 1'b0);
    check("rst_instr", ir_instr, 32'h0);
    check("rst_pc", ir_pc, 32'h0);
    step();
    rst = 1'b0;
    #1;
    // Sequential fetch with single-cycle memory, consumer always ready
    check("p1_req", imem_req, 1'b1);
    check("p1_addr", imem_addr, 32'h0000_3000);
    check("p1_valid_n", ir_valid, 1'b0);
    step();
    check("p1_wait_req", imem_req, 1'b0);
    check("p1_valid_n1", ir_valid, 1'b0);
    step();
    check("p1_valid_n2", ir_valid, 1'b1);
    check("p1_pc0", ir_pc, 32'h0000_3000);
    check("p1_instr0", ir_instr, 32'hA5A5_3000);
    step(); step();
    check("p1_pc1", ir_pc, 32'h0000_3004);
    check("p1_instr1", ir_instr, 32'hA5A5_3004);
    step(); step();
    check("p1_pc2", ir_pc, 32'h0000_3008);

    // Fill with consumer stalled, then drain
    do_reset();
    ir_ready = 1'b0;
    repeat (10) step();
    check("p2_full_valid", ir_valid, 1'b1);
    check("p2_full_req", imem_req, 1'b0);
    check("p2_full_head", ir_pc, 32'h0000_3000);
    check("p2_full_addr", imem_addr, 32'h0000_3010);
    ir_ready = 1'b1;
    #1;
    check("p2_pop0", ir_pc, 32'h0000_3000);
    step();
    check("p2_pop1", ir_pc, 32'h0000_3004);
    check("p2_resume_req", imem_req, 1'b1);
    check("p2_resume_addr", imem_addr, 32'h0000_3010);
    step();
    check("p2_pop2", ir_pc, 32'h0000_3008);
    step();
    check("p2_pop3", ir_pc, 32'h0000_300C);
    step();
    check("p2_pop4", ir_pc, 32'h0000_3010);

    // Redirect while waiting; the stale response must be dropped
    mem_auto = 1'b0;
    do_reset();
    gnt_man = 1'b1;
    #1;
    check("p3_req", imem_req, 1'b1);
    check("p3_addr", imem_addr, 32'h0000_3000);
    step();
    gnt_man = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_4003;
    #1;
    check("p3_wait_req", imem_req, 1'b0);
    step();
    redirect = 1'b0; rv_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
    #1;
    check("p3_drop_req", imem_req, 1'b0);
    check("p3_drop_valid", ir_valid, 1'b0);
    step();
    rv_man = 1'b0; gnt_man = 1'b1;
    #1;
    check("p3_dropped_valid", ir_valid, 1'b0);
    check("p3_new_req", imem_req, 1'b1);
    check("p3_new_addr", imem_addr, 32'h0000_4000);
    step();
    gnt_man = 1'b0; rv_man = 1'b1; rdata_man = 32'h1111_1111;
    step();
    rv_man = 1'b0;
    #1;
    check("p3_head_valid", ir_valid, 1'b1);
    check("p3_head_pc", ir_pc, 32'h0000_4000);
    check("p3_head_instr", ir_instr, 32'h1111_1111);

    // Redirect coinciding with a response and with a pop of a valid head
    ir_ready = 1'b0; gnt_man = 1'b1;
    step();
    gnt_man = 1'b0; rv_man = 1'b1; rdata_man = 32'h2222_2222;
    redirect = 1'b1; redirect_pc = 32'h0000_5000; ir_ready = 1'b1;
    #1;
    check("p4_pre_valid", ir_valid, 1'b1);
    step();
    redirect = 1'b0; rv_man = 1'b0; gnt_man = 1'b1;
    #1;
    check("p4_flushed", ir_valid, 1'b0);
    check("p4_req", imem_req, 1'b1);
    check("p4_addr", imem_addr, 32'h0000_5000);
    step();
    gnt_man = 1'b0; rv_man = 1'b1; rdata_man = 32'h3333_3333;
    step();
    rv_man = 1'b0;
    #1;
    check("p4_head_pc", ir_pc, 32'h0000_5000);
    check("p4_head_instr", ir_instr, 32'h3333_3333);

    // Redirect near the top of the address space; fetch_pc wraps
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    #1;
    check("p5_withdrawn", imem_req, 1'b0);
    step();
    redirect = 1'b0; mem_auto = 1'b1;
    #1;
    check("p5_addr", imem_addr, 32'hFFFF_FFF8);
    step(); step();
    check("p5_pc0", ir_pc, 32'hFFFF_FFF8);
    check("p5_instr0", ir_instr, 32'h5A5A_FFF8);
    step(); step();
    check("p5_pc1", ir_pc, 32'hFFFF_FFFC);
    step(); step();
    check("p5_pc2", ir_pc, 32'h0000_0000);
    check("p5_instr2", ir_instr, 32'hA5A5_0000);

    // Reset from a full queue, then from DROP with a late response
    do_reset();
    ir_ready = 1'b0;
    repeat (10) step();
    check("p6_full_valid", ir_valid, 1'b1);
    check("p6_full_req", imem_req, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0; mem_auto = 1'b0; gnt_man = 1'b1;
    #1;
    check("p6_rst_valid", ir_valid, 1'b0);
    check("p6_rst_addr", imem_addr, 32'h0000_3000);
    check("p6_rst_pc", ir_pc, 32'h0);
    step();
    gnt_man = 1'b0; redirect = 1'b1; redirect_pc = 32'h0000_6000;
    step();
    redirect = 1'b0; rst = 1'b1;
    #1;
    check("p6_drop_req", imem_req, 1'b0);
    step();
    rst = 1'b0; rv_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
    #1;
    check("p6_drop_rst_req", imem_req, 1'b1);
    check("p6_drop_rst_addr", imem_addr, 32'h0000_3000);
    check("p6_drop_rst_valid", ir_valid, 1'b0);
`ifdef FETCH_STAT_EN
    check("p6_stat_fetched", stat_fetched, 32'h0);
    check("p6_stat_stall", stat_stall, 32'h0);
    check("p6_stat_flush", stat_flush, 32'h0);
`endif
    step();
    rv_man = 1'b0;
    #1;
    check("p6_late_ignored", ir_valid, 1'b0);
    check("p6_late_addr", imem_addr, 32'h0000_3000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
